id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register for the RV32IM core. Sits directly upstream of the ALU and drives data1, data2 and ALU_OPCODE.
//  Captures decoded operands and control each cycle, and applies EX/MEM and MEM/WB forwarding to the registered operands.
//  Detects load-use hazards and inserts bubbles.
//  Honours STALL (hold) and FLUSH (kill) from the hazard/branch logic.
// PARAMETERS
//  XLEN     32  datapath width
//  OPW      5   ALU opcode width (matches alu.ALU_OPCODE)
//  NOP_OP   5'b00000  opcode driven during a bubble/reset (ADD)
// PORTS
//  CLK               in   1     clock, rising edge
//  RESETn            in   1     async reset, active-low
//  ID_VALID          in   1     ID holds a valid instruction
//  ID_PC             in   XLEN  PC of ID instruction
//  ID_DATA1/ID_DATA2 in   XLEN  register-file read values rs1/rs2
//  ID_IMM            in   XLEN  sign-extended immediate
//  ID_IMM_SEL        in   1     1: ALU operand 2 = immediate
//  ID_ALU_OPCODE     in   OPW   decoded ALU operation
//  ID_RS1/ID_RS2/ID_RD in 5     register indices
//  ID_REG_WRITE      in   1     writes rd
//  ID_MEM_READ       in   1     is a load
//  ID_MEM_WRITE      in   1     is a store
//  STALL             in   1     downstream hold; register keeps contents
//  FLUSH             in   1     kill EX-stage contents (branch taken)
//  EXMEM_RD/MEMWB_RD in   5     destination registers of later stages
//  EXMEM_REG_WRITE/MEMWB_REG_WRITE in 1  later-stage write enables
//  EXMEM_RESULT/MEMWB_RESULT in XLEN  values available for forwarding
//  data1             out  XLEN  ALU operand 1 (forwarded rs1)
//  data2             out  XLEN  ALU operand 2 (IMM or forwarded rs2)
//  ALU_OPCODE        out  OPW   ALU operation
//  EX_VALID, EX_PC, EX_RD, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  out  registered control passed downstream
//  EX_STORE_DATA     out  XLEN  forwarded rs2 for stores
//  LOAD_USE_HAZARD   out  1     combinational; upstream must hold PC and IF/ID
// BEHAVIOUR
//  Reset (RESETn=0, async): all registers take the bubble value.
//   Bubble: VALID=0, REG_WRITE/MEM_READ/MEM_WRITE=0, RD=0, PC/DATA/IMM=0, IMM_SEL=0, OPCODE=NOP_OP.
//   data1=data2=0 and LOAD_USE_HAZARD=0 while in reset.
//  Per-edge update, in priority order:
//   1. FLUSH=1 -> load bubble.
//   2. STALL=1 -> hold all registers.
//   3. LOAD_USE_HAZARD=1 -> load bubble.
//   4. Else load ID_* fields. ID_VALID=0 loads a bubble.
//  LOAD_USE_HAZARD = EX_VALID & EX_MEM_READ & EX_RD!=0 & ID_VALID & (ID_RS1==EX_RD | ID_RS2==EX_RD).
//   Gives exactly one bubble per load-use pair: next cycle the load has left EX.
//  Forwarding (combinational, per operand, using registered rs index r):
//   If EXMEM_REG_WRITE & EXMEM_RD==r & r!=0 -> EXMEM_RESULT.
//   Else if MEMWB_REG_WRITE & MEMWB_RD==r & r!=0 -> MEMWB_RESULT.
//   Else registered DATA. EX/MEM has priority over MEM/WB. x0 is never forwarded.
//  data2 = IMM_SEL ? IMM : fwd_rs2. EX_STORE_DATA = fwd_rs2 always.
//  Latency: ID fields appear on ALU inputs 1 cycle after capture.
//  STALL+hazard in the same cycle: hold wins; hazard re-evaluates next cycle.
//  FLUSH mid-stall clears the stage.
//  Reset asserted mid-operation: stage becomes a bubble immediately (async), with no partial update.
// TESTING
//  1. Reset: RESETn=0 with ID_VALID=1 -> EX_VALID=0, ALU_OPCODE=0, data1=data2=0.
//     Release, then ID add x3,x1,x2 (10,20) -> next cycle data1=10, data2=20, OPCODE=00000.
//  2. Forward priority: EX rs1=x5 regs=1, EXMEM_RD=5 RESULT=7, MEMWB_RD=5 RESULT=9 -> data1=7.
//     Drop EXMEM_REG_WRITE -> data1=9. With rs1=x0 and both matching -> data1=0.
//  3. Load-use: EX lw x4 (MEM_READ=1, RD=4), ID uses rs2=x4 -> LOAD_USE_HAZARD=1.
//     Next edge EX_VALID=0 and hazard=0. The following edge captures the instruction.
//  4. STALL=1 for 3 cycles with changing ID inputs -> EX outputs constant.
//     Release -> current ID captured on the next edge.
//  5. FLUSH=1 with STALL=1 and valid ID -> next cycle EX_VALID=0, REG_WRITE=0, OPCODE=NOP_OP.
//  6. Immediate: IMM_SEL=1, IMM=-4, rs2 forward active with 55 -> data2=32'hFFFFFFFC, EX_STORE_DATA=55.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32IM core: operand forwarding,
// load-use bubble insertion, stall hold and branch flush.
module id_ex_stage #(
    parameter int unsigned    XLEN   = 32,
    parameter int unsigned    OPW    = 5,
    parameter logic [OPW-1:0] NOP_OP = '0
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            ID_VALID,
    input  logic [XLEN-1:0] ID_PC,
    input  logic [XLEN-1:0] ID_DATA1,
    input  logic [XLEN-1:0] ID_DATA2,
    input  logic [XLEN-1:0] ID_IMM,
    input  logic            ID_IMM_SEL,
    input  logic [OPW-1:0]  ID_ALU_OPCODE,
    input  logic [4:0]      ID_RS1,
    input  logic [4:0]      ID_RS2,
    input  logic [4:0]      ID_RD,
    input  logic            ID_REG_WRITE,
    input  logic            ID_MEM_READ,
    input  logic            ID_MEM_WRITE,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic [4:0]      EXMEM_RD,
    input  logic [4:0]      MEMWB_RD,
    input  logic            EXMEM_REG_WRITE,
    input  logic            MEMWB_REG_WRITE,
    input  logic [XLEN-1:0] EXMEM_RESULT,
    input  logic [XLEN-1:0] MEMWB_RESULT,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output logic [OPW-1:0]  ALU_OPCODE,
    output logic            EX_VALID,
    output logic [XLEN-1:0] EX_PC,
    output logic [4:0]      EX_RD,
    output logic            EX_REG_WRITE,
    output logic            EX_MEM_READ,
    output logic            EX_MEM_WRITE,
    output logic [XLEN-1:0] EX_STORE_DATA,
    output logic            LOAD_USE_HAZARD
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        logic [OPW-1:0]  op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_t;

    ex_t ex_q, ex_d, bubble, id_in;
    logic hazard;
    logic [XLEN-1:0] fwd1, fwd2;

    always_comb begin
        bubble    = '0;
        bubble.op = NOP_OP;
    end

    always_comb begin
        id_in.valid     = 1'b1;
        id_in.pc        = ID_PC;
        id_in.d1        = ID_DATA1;
        id_in.d2        = ID_DATA2;
        id_in.imm       = ID_IMM;
        id_in.imm_sel   = ID_IMM_SEL;
        id_in.op        = ID_ALU_OPCODE;
        id_in.rs1       = ID_RS1;
        id_in.rs2       = ID_RS2;
        id_in.rd        = ID_RD;
        id_in.reg_write = ID_REG_WRITE;
        id_in.mem_read  = ID_MEM_READ;
        id_in.mem_write = ID_MEM_WRITE;
    end

    // A load in EX whose rd feeds the ID instruction cannot be forwarded yet
    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0)
                    && ID_VALID
                    && ((ID_RS1 == ex_q.rd) || (ID_RS2 == ex_q.rd));

    always_comb begin
        ex_d = ex_q;
        if (FLUSH) begin
            ex_d = bubble;
        end else if (STALL) begin
            ex_d = ex_q;
        end else if (hazard || !ID_VALID) begin
            ex_d = bubble;
        end else begin
            ex_d = id_in;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB
    always_comb begin
        fwd1 = ex_q.d1;
        if (EXMEM_REG_WRITE && (EXMEM_RD == ex_q.rs1) && (ex_q.rs1 != 5'd0)) begin
            fwd1 = EXMEM_RESULT;
        end else if (MEMWB_REG_WRITE && (MEMWB_RD == ex_q.rs1) && (ex_q.rs1 != 5'd0)) begin
            fwd1 = MEMWB_RESULT;
        end
    end

    always_comb begin
        fwd2 = ex_q.d2;
        if (EXMEM_REG_WRITE && (EXMEM_RD == ex_q.rs2) && (ex_q.rs2 != 5'd0)) begin
            fwd2 = EXMEM_RESULT;
        end else if (MEMWB_REG_WRITE && (MEMWB_RD == ex_q.rs2) && (ex_q.rs2 != 5'd0)) begin
            fwd2 = MEMWB_RESULT;
        end
    end

    assign data1           = fwd1;
    assign data2           = ex_q.imm_sel ? ex_q.imm : fwd2;
    assign EX_STORE_DATA   = fwd2;
    assign ALU_OPCODE      = ex_q.op;
    assign EX_VALID        = ex_q.valid;
    assign EX_PC           = ex_q.pc;
    assign EX_RD           = ex_q.rd;
    assign EX_REG_WRITE    = ex_q.reg_write;
    assign EX_MEM_READ     = ex_q.mem_read;
    assign EX_MEM_WRITE    = ex_q.mem_write;
    assign LOAD_USE_HAZARD = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a
// behavioural model compared against the outputs every cycle.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        ID_VALID;
    logic [31:0] ID_PC, ID_DATA1, ID_DATA2, ID_IMM;
    logic        ID_IMM_SEL;
    logic [4:0]  ID_ALU_OPCODE, ID_RS1, ID_RS2, ID_RD;
    logic        ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
    logic        STALL, FLUSH;
    logic [4:0]  EXMEM_RD, MEMWB_RD;
    logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
    logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
    logic [31:0] data1, data2, EX_PC, EX_STORE_DATA;
    logic [4:0]  ALU_OPCODE, EX_RD;
    logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE;
    logic        LOAD_USE_HAZARD;

    int tests = 0;
    int fails = 0;

    id_ex_stage dut (
        .CLK(CLK), .RESETn(RESETn), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2), .ID_IMM(ID_IMM),
        .ID_IMM_SEL(ID_IMM_SEL), .ID_ALU_OPCODE(ID_ALU_OPCODE),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ),
        .ID_MEM_WRITE(ID_MEM_WRITE), .STALL(STALL), .FLUSH(FLUSH),
        .EXMEM_RD(EXMEM_RD), .MEMWB_RD(MEMWB_RD),
        .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .MEMWB_REG_WRITE(MEMWB_REG_WRITE),
        .EXMEM_RESULT(EXMEM_RESULT), .MEMWB_RESULT(MEMWB_RESULT),
        .data1(data1), .data2(data2), .ALU_OPCODE(ALU_OPCODE),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_RD(EX_RD),
        .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ),
        .EX_MEM_WRITE(EX_MEM_WRITE), .EX_STORE_DATA(EX_STORE_DATA),
        .LOAD_USE_HAZARD(LOAD_USE_HAZARD)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction currently sitting in EX, or none
    typedef struct {
        bit          valid;
        logic [31:0] pc, d1, d2, imm;
        bit          isel;
        logic [4:0]  op, rs1, rs2, rd;
        bit          rw, mr, mw;
    } instr_t;

    instr_t m;

    function automatic instr_t none();
        instr_t b;
        b.valid = 0; b.pc = 0; b.d1 = 0; b.d2 = 0; b.imm = 0; b.isel = 0;
        b.op = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.rw = 0; b.mr = 0; b.mw = 0;
        return b;
    endfunction

    function automatic bit mhaz();
        return m.valid && m.mr && m.rd != 0 && ID_VALID
               && (ID_RS1 == m.rd || ID_RS2 == m.rd);
    endfunction

    function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] v);
        if (r == 0) return v;
        if (EXMEM_REG_WRITE && EXMEM_RD == r) return EXMEM_RESULT;
        if (MEMWB_REG_WRITE && MEMWB_RD == r) return MEMWB_RESULT;
        return v;
    endfunction

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) m = none();
        else if (FLUSH) m = none();
        else if (STALL) m = m;
        else if (mhaz() || !ID_VALID) m = none();
        else begin
            m.valid = 1; m.pc = ID_PC; m.d1 = ID_DATA1; m.d2 = ID_DATA2;
            m.imm = ID_IMM; m.isel = ID_IMM_SEL; m.op = ID_ALU_OPCODE;
            m.rs1 = ID_RS1; m.rs2 = ID_RS2; m.rd = ID_RD;
            m.rw = ID_REG_WRITE; m.mr = ID_MEM_READ; m.mw = ID_MEM_WRITE;
        end
    end

    always @(negedge CLK) begin
        check("m_data1", data1, mfwd(m.rs1, m.d1));
        check("m_data2", data2, m.isel ? m.imm : mfwd(m.rs2, m.d2));
        check("m_store", EX_STORE_DATA, mfwd(m.rs2, m.d2));
        check("m_op", 32'(ALU_OPCODE), 32'(m.op));
        check("m_valid", 32'(EX_VALID), 32'(m.valid));
        check("m_pc", EX_PC, m.pc);
        check("m_rd", 32'(EX_RD), 32'(m.rd));
        check("m_ctl", {29'd0, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE},
              {29'd0, m.rw, m.mr, m.mw});
        check("m_haz", 32'(LOAD_USE_HAZARD), 32'(mhaz()));
    end

    task automatic set_id(input bit v, input logic [31:0] pc, d1, d2, imm,
                          input bit isel, input logic [4:0] op, rs1, rs2, rd,
                          input bit rw, mr, mw);
        ID_VALID = v; ID_PC = pc; ID_DATA1 = d1; ID_DATA2 = d2; ID_IMM = imm;
        ID_IMM_SEL = isel; ID_ALU_OPCODE = op; ID_RS1 = rs1; ID_RS2 = rs2;
        ID_RD = rd; ID_REG_WRITE = rw; ID_MEM_READ = mr; ID_MEM_WRITE = mw;
    endtask

    task automatic clear_fwd();
        EXMEM_RD = 0; MEMWB_RD = 0; EXMEM_REG_WRITE = 0; MEMWB_REG_WRITE = 0;
        EXMEM_RESULT = 0; MEMWB_RESULT = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn = 0; STALL = 0; FLUSH = 0;
        clear_fwd();
        set_id(1, 32'h100, 10, 20, 0, 0, 0, 1, 2, 3, 1, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", 32'(EX_VALID), 0);
        check("rst_op", 32'(ALU_OPCODE), 0);
        check("rst_d1", data1, 0);
        check("rst_d2", data2, 0);
        check("rst_haz", 32'(LOAD_USE_HAZARD), 0);
        RESETn = 1;
        tick();
        check("add_d1", data1, 10);
        check("add_d2", data2, 20);
        check("add_op", 32'(ALU_OPCODE), 0);
        check("add_rd", 32'(EX_RD), 3);

        set_id(1, 32'h104, 1, 2, 0, 0, 1, 5, 6, 7, 1, 0, 0);
        tick();
        EXMEM_RD = 5; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 7;
        MEMWB_RD = 5; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 9;
        #1 check("fwd_exmem", data1, 7);
        EXMEM_REG_WRITE = 0;
        #1 check("fwd_memwb", data1, 9);
        EXMEM_REG_WRITE = 1; EXMEM_RD = 0; MEMWB_RD = 0;
        set_id(1, 32'h108, 0, 2, 0, 0, 0, 0, 6, 8, 1, 0, 0);
        tick();
        check("fwd_x0", data1, 0);
        clear_fwd();

        set_id(1, 32'h10c, 100, 0, 8, 1, 0, 1, 0, 4, 1, 1, 0);
        tick();
        set_id(1, 32'h110, 1, 2, 0, 0, 0, 1, 4, 5, 1, 0, 0);
        #1 check("lu_haz", 32'(LOAD_USE_HAZARD), 1);
        tick();
        check("lu_bubble", 32'(EX_VALID), 0);
        check("lu_haz_clr", 32'(LOAD_USE_HAZARD), 0);
        tick();
        check("lu_cap_v", 32'(EX_VALID), 1);
        check("lu_cap_pc", EX_PC, 32'h110);

        STALL = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h200 + 32'(4 * i), 32'(i), 32'(i), 0, 0, 5'(i + 2),
                   1, 2, 5'(9 + i), 1, 0, 0);
            tick();
            check("stall_pc", EX_PC, 32'h110);
            check("stall_rd", 32'(EX_RD), 5);
        end
        set_id(1, 32'h300, 3, 4, 0, 0, 2, 10, 11, 12, 1, 0, 0);
        STALL = 0;
        tick();
        check("unstall_pc", EX_PC, 32'h300);
        check("unstall_rd", 32'(EX_RD), 12);

        STALL = 1; FLUSH = 1;
        set_id(1, 32'h304, 1, 1, 0, 0, 3, 1, 2, 13, 1, 0, 0);
        tick();
        check("flush_v", 32'(EX_VALID), 0);
        check("flush_rw", 32'(EX_REG_WRITE), 0);
        check("flush_op", 32'(ALU_OPCODE), 0);
        STALL = 0; FLUSH = 0;

        set_id(1, 32'h308, 1, 3, 32'hFFFF_FFFC, 1, 0, 1, 7, 0, 0, 0, 1);
        tick();
        MEMWB_RD = 7; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 55;
        #1 check("imm_d2", data2, 32'hFFFF_FFFC);
        check("imm_store", EX_STORE_DATA, 55);
        clear_fwd();

        set_id(1, 32'h400, 5, 6, 0, 0, 4, 1, 2, 13, 1, 0, 0);
        tick();
        check("arst_pre", 32'(EX_VALID), 1);
        #1 RESETn = 0;
        #1 check("arst_v", 32'(EX_VALID), 0);
        check("arst_pc", EX_PC, 0);
        check("arst_op", 32'(ALU_OPCODE), 0);
        tick();
        RESETn = 1;

        for (int i = 0; i < 80; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                   $urandom, 1'($urandom), 5'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom));
            STALL = $urandom_range(0, 7) == 0;
            FLUSH = $urandom_range(0, 15) == 0;
            EXMEM_RD = 5'($urandom_range(0, 3));
            MEMWB_RD = 5'($urandom_range(0, 3));
            EXMEM_REG_WRITE = 1'($urandom);
            MEMWB_REG_WRITE = 1'($urandom);
            EXMEM_RESULT = $urandom;
            MEMWB_RESULT = $urandom;
            tick();
        end

        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
